// File: rtl/segment_led_interface_if.sv
// segment_led_interface_if: switch inputs and anode/cathode pins of the two-digit display
interface segment_led_interface_if;
  logic switch0;
  logic switch1;
  logic a0;
  logic a1;
  logic [3:0] count;
  logic [6:0] cathode;
  modport master(output switch0, switch1, input a0, a1, count, cathode);
  modport slave(input switch0, switch1, output a0, a1, count, cathode);
endinterface

// File: rtl/segment_led_interface.sv
// segment_led_interface: two-digit multiplexed 7-segment driver (record/play clip); define SWITCH_SYNC_EN to synchronize switches
module segment_led_interface #(
  parameter int REFRESH_BITS = 2
) (
  input logic clock,
  input logic reset,
  segment_led_interface_if.slave bus
);
  logic [REFRESH_BITS-1:0] rc;
  logic sw0, sw1, sel;
  logic [3:0] cnt_d;
  logic [6:0] cat_d;
`ifdef SWITCH_SYNC_EN
  logic [1:0] s0, s1;
  // two-flop synchronizers on the slide switches
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      s0 <= '0;
      s1 <= '0;
    end else begin
      s0 <= {s0[0], bus.switch0};
      s1 <= {s1[0], bus.switch1};
    end
  assign sw0 = s0[1];
  assign sw1 = s1[1];
`else
  assign sw0 = bus.switch0;
  assign sw1 = bus.switch1;
`endif
  assign sel = rc[REFRESH_BITS-1];
  assign cnt_d = (sel ? sw1 : sw0) ? 4'd2 : 4'd1;
  // active-low hex decode of the value about to be loaded into count
  always_comb begin
    cat_d = 7'h7F;
    case (cnt_d)
      4'h0: cat_d = 7'h01;
      4'h1: cat_d = 7'h4F;
      4'h2: cat_d = 7'h12;
      4'h3: cat_d = 7'h06;
      4'h4: cat_d = 7'h4C;
      4'h5: cat_d = 7'h24;
      4'h6: cat_d = 7'h20;
      4'h7: cat_d = 7'h0F;
      4'h8: cat_d = 7'h00;
      4'h9: cat_d = 7'h04;
      4'hA: cat_d = 7'h08;
      4'hB: cat_d = 7'h60;
      4'hC: cat_d = 7'h31;
      4'hD: cat_d = 7'h42;
      4'hE: cat_d = 7'h30;
      4'hF: cat_d = 7'h38;
      default: cat_d = 7'h7F;
    endcase
  end
  // refresh counter and registered outputs loaded from the current scan slot
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      rc <= '0;
      bus.a0 <= 1'b1;
      bus.a1 <= 1'b1;
      bus.count <= 4'h0;
      bus.cathode <= 7'h7F;
    end else begin
      rc <= rc + REFRESH_BITS'(1);
      bus.a0 <= sel;
      bus.a1 <= ~sel;
      bus.count <= cnt_d;
      bus.cathode <= cat_d;
    end
endmodule

// File: tb/tb_segment_led_interface.sv
// tb_segment_led_interface: directed checks of scan order, clip digits, reset and switch latency
module tb_segment_led_interface;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
`ifdef SWITCH_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  segment_led_interface_if bus();
  segment_led_interface #(.REFRESH_BITS(2)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  task automatic run(input logic s0, input logic s1, input int n, input int tog);
    logic h0[$];
    logic h1[$];
    logic e0, e1, d;
    logic [3:0] ec;
    @(negedge clock);
    #2 reset = 1'b1;
    bus.switch0 = s0;
    bus.switch1 = s1;
    #1;
    check("rst_a0", bus.a0, 1);
    check("rst_a1", bus.a1, 1);
    check("rst_count", bus.count, 0);
    check("rst_cathode", bus.cathode, 7'h7F);
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < n; k++) begin
      h0.push_back(bus.switch0);
      h1.push_back(bus.switch1);
      @(posedge clock);
      #1;
      d = k[1];
      e0 = (k >= LAT) ? h0[k-LAT] : 1'b0;
      e1 = (k >= LAT) ? h1[k-LAT] : 1'b0;
      ec = (d ? e1 : e0) ? 4'd2 : 4'd1;
      check($sformatf("a0@%0d", k), bus.a0, d);
      check($sformatf("a1@%0d", k), bus.a1, !d);
      check($sformatf("one_lit@%0d", k), bus.a0 | bus.a1, 1);
      check($sformatf("count@%0d", k), bus.count, ec);
      check($sformatf("cathode@%0d", k), bus.cathode, ec == 4'd2 ? 7'h12 : 7'h4F);
      if (k == tog) bus.switch0 = ~bus.switch0;
    end
  endtask
  initial begin
    bus.switch0 = 1'b0;
    bus.switch1 = 1'b0;
    repeat (2) @(posedge clock);
    run(0, 0, 2, -1);
    run(0, 0, 20, -1);
    run(1, 0, 8, -1);
    run(0, 1, 8, -1);
    run(1, 1, 8, -1);
    run(0, 0, 12, 4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
